stack_op_issuer: RTL and testbench

//  Upstream driver of register_stack. Accepts one decoded stack instruction per handshake.

---
 rtl/stack_op_issuer.sv | 141 ++++++++++++++
 tb/tb_stack_op_issuer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_op_issuer.sv
// rtl/stack_op_issuer.sv - decodes stack instructions into register_stack commands
// Tracks depth, rejects under/overflow, and runs a shift-add MUL over WIDTH cycles.
module stack_op_issuer #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       stackOP,
  output logic [WIDTH-1:0] w,
  output logic [4:0]       depth,
  output logic             busy,
  output logic             err
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL_RUN, MUL_WB} state_t;

  state_t           state_q, state_d;
  logic [4:0]       depth_q, depth_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    count_q, count_d;

  logic [2:0]       op_code;
  logic [WIDTH-1:0] op_w;
  logic [1:0]       need;
  logic             up;
  logic [1:0]       down;
  logic             is_mul;
  logic [5:0]       depth_after;
  logic             legal;

  always_comb begin
    op_code = 3'd0;
    op_w    = '0;
    need    = 2'd0;
    up      = 1'b0;
    down    = 2'd0;
    is_mul  = 1'b0;
    case (in_op)
      4'd1:  begin op_code = 3'd1; op_w = in_imm; up = 1'b1; end
      4'd2:  begin op_code = 3'd2; op_w = b + a; need = 2'd2; down = 2'd1; end
      4'd3:  begin op_code = 3'd2; op_w = b - a; need = 2'd2; down = 2'd1; end
      4'd4:  begin op_code = 3'd2; op_w = b | a; need = 2'd2; down = 2'd1; end
      4'd5:  begin op_code = 3'd2; op_w = (b < a) ? WIDTH'(1) : '0; need = 2'd2; down = 2'd1; end
      4'd6:  begin op_code = 3'd3; need = 2'd1; down = 2'd1; end
      4'd7:  begin op_code = 3'd4; need = 2'd2; down = 2'd2; end
      4'd8:  begin op_code = 3'd5; need = 2'd2; end
      4'd9:  begin op_code = 3'd1; op_w = a; need = 2'd1; up = 1'b1; end
      4'd10: begin op_code = 3'd1; op_w = b; need = 2'd2; up = 1'b1; end
      4'd11: begin is_mul = 1'b1; need = 2'd2; down = 2'd1; end
      default: ;
    endcase
  end

  // Underflow check guards the subtraction, so a wrapped depth_after never matters.
  assign depth_after = {1'b0, depth_q} + {5'b0, up} - {4'b0, down};
  assign legal       = ({3'b0, need} <= depth_q) && (depth_after <= 6'(DEPTH));

  always_comb begin
    state_d  = state_q;
    depth_d  = depth_q;
    err_d    = err_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    stackOP  = 3'd0;
    w        = '0;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !Reset;
        if (in_valid && !Reset) begin
          if (!legal) begin
            err_d = 1'b1;
          end else if (is_mul) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            count_d  = '0;
            state_d  = MUL_RUN;
          end else begin
            stackOP = op_code;
            w       = op_w;
            depth_d = depth_after[4:0];
          end
        end
      end
      MUL_RUN: begin
        busy = 1'b1;
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) state_d = MUL_WB;
      end
      MUL_WB: begin
        busy    = 1'b1;
        stackOP = 3'd2;
        w       = acc_q;
        depth_d = depth_q - 5'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      depth_q  <= '0;
      err_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      depth_q  <= depth_d;
      err_q    <= err_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
    end
  end

  assign depth = depth_q;
  assign err   = err_q;
endmodule

// File: tb/tb_stack_op_issuer.sv
// tb/tb_stack_op_issuer.sv - randomized bench for stack_op_issuer
// A queue-based stack model supplies a/b and predicts every output each cycle.
module tb_stack_op_issuer;
  localparam int DEPTH = 16;
  localparam int WIDTH = 16;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [15:0] in_imm = '0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [2:0]  stackOP;
  logic [15:0] w;
  logic [4:0]  depth;
  logic        busy;
  logic        err;

  stack_op_issuer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .CLK(CLK), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_imm(in_imm), .a(a), .b(b),
    .stackOP(stackOP), .w(w), .depth(depth), .busy(busy), .err(err)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  logic [15:0] stk[$];
  bit          m_err = 0;
  int          m_busy = 0;
  logic [15:0] m_res = '0;

  logic [2:0]  e_op;
  logic [15:0] e_w;
  bit          e_ready, e_accept, e_ok, e_mul;
  logic [15:0] e_av, e_bv;

  logic [2:0]  obs_op;
  logic [15:0] obs_w;
  logic        obs_ready, obs_busy;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_ab();
    int n = stk.size();
    a = (n > 0) ? stk[n-1] : 16'hDEAD;
    b = (n > 1) ? stk[n-2] : 16'hBEEF;
  endtask

  task automatic predict();
    int n = stk.size();
    int need = 0;
    int delta = 0;
    logic [31:0] p;
    e_av = (n > 0) ? stk[n-1] : '0;
    e_bv = (n > 1) ? stk[n-2] : '0;
    e_op = 0; e_w = 0; e_ok = 0; e_mul = 0;
    e_ready  = !Reset && (m_busy == 0);
    e_accept = e_ready && in_valid;
    if (Reset) return;
    if (m_busy == 1) begin e_op = 2; e_w = m_res; end
    if (e_accept) begin
      case (in_op)
        1:  begin need = 0; delta =  1; e_op = 1; e_w = in_imm; end
        2:  begin need = 2; delta = -1; e_op = 2; e_w = e_bv + e_av; end
        3:  begin need = 2; delta = -1; e_op = 2; e_w = e_bv - e_av; end
        4:  begin need = 2; delta = -1; e_op = 2; e_w = e_bv | e_av; end
        5:  begin need = 2; delta = -1; e_op = 2; e_w = (e_bv < e_av) ? 16'd1 : 16'd0; end
        6:  begin need = 1; delta = -1; e_op = 3; end
        7:  begin need = 2; delta = -2; e_op = 4; end
        8:  begin need = 2; delta =  0; e_op = 5; end
        9:  begin need = 1; delta =  1; e_op = 1; e_w = e_av; end
        10: begin need = 2; delta =  1; e_op = 1; e_w = e_bv; end
        11: begin need = 2; delta = -1; e_mul = 1; end
        default: ;
      endcase
      e_ok = (n >= need) && (n + delta <= DEPTH);
      if (!e_ok || e_mul) begin e_op = 0; e_w = 0; end
      if (e_mul && e_ok) begin
        p = {16'd0, e_bv} * {16'd0, e_av};
        m_res = p[15:0];
      end
    end
  endtask

  task automatic compare();
    obs_op = stackOP; obs_w = w; obs_ready = in_ready; obs_busy = busy;
    check("stackOP", 32'(stackOP), 32'(e_op));
    check("w", 32'(w), 32'(e_w));
    check("in_ready", 32'(in_ready), 32'(e_ready));
    check("busy", 32'(busy), 32'(m_busy > 0));
    check("depth", 32'(depth), 32'(stk.size()));
    check("err", 32'(err), 32'(m_err));
  endtask

  task automatic commit();
    logic [15:0] t0, t1;
    if (Reset) return;
    if (m_busy == 1) begin
      void'(stk.pop_back()); void'(stk.pop_back()); stk.push_back(m_res);
      m_busy = 0;
    end else if (m_busy > 1) begin
      m_busy--;
    end else if (e_accept) begin
      if (!e_ok) m_err = 1;
      else if (e_mul) m_busy = WIDTH + 1;
      else case (e_op)
        1: stk.push_back(e_w);
        2: begin void'(stk.pop_back()); void'(stk.pop_back()); stk.push_back(e_w); end
        3: void'(stk.pop_back());
        4: begin void'(stk.pop_back()); void'(stk.pop_back()); end
        5: begin t0 = stk.pop_back(); t1 = stk.pop_back(); stk.push_back(t0); stk.push_back(t1); end
        default: ;
      endcase
    end
  endtask

  task automatic cycle(bit v, logic [3:0] op, logic [15:0] imm);
    in_valid = v; in_op = op; in_imm = imm;
    drive_ab();
    @(negedge CLK);
    predict();
    compare();
    @(posedge CLK);
    commit();
    #1;
  endtask

  task automatic do_reset();
    Reset = 1; stk.delete(); m_err = 0; m_busy = 0;
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    Reset = 0;
  endtask

  int nbusy;
  logic [15:0] wb_w;
  logic [3:0] rop;

  initial begin
    #1;
    do_reset();
    check("reset_depth", 32'(depth), 32'd0);
    check("reset_err", 32'(err), 32'd0);

    cycle(1, 1, 1);  check("push1_op", 32'(obs_op), 32'd1);
    cycle(1, 1, 2);  check("push2_op", 32'(obs_op), 32'd1);
    cycle(1, 5, 0);  check("slt_op", 32'(obs_op), 32'd2);
    check("slt_w", 32'(obs_w), 32'd1);
    check("slt_depth", 32'(depth), 32'd1);
    check("slt_top", 32'(stk[0]), 32'd1);

    do_reset();
    cycle(1, 1, 7); cycle(1, 1, 5);
    cycle(1, 3, 0);  check("sub_w", 32'(obs_w), 32'd2);
    cycle(1, 8, 0);  check("swap_rej_op", 32'(obs_op), 32'd0);
    check("swap_rej_err", 32'(err), 32'd1);
    check("swap_rej_depth", 32'(depth), 32'd1);

    do_reset();
    cycle(1, 1, 300); cycle(1, 1, 500);
    cycle(1, 11, 0); check("mul_accept_op", 32'(obs_op), 32'd0);
    nbusy = 0; wb_w = 0;
    for (int i = 0; i < 30 && (m_busy > 0); i++) begin
      cycle(1, 1, 16'h1234);
      if (obs_busy) nbusy++;
      if (obs_busy && obs_ready) check("mul_ready_low", 32'(obs_ready), 32'd0);
      if (obs_op == 3'd2) wb_w = obs_w;
    end
    check("mul_busy_cycles", 32'(nbusy), 32'd17);
    check("mul_result", 32'(wb_w), 32'd18928);
    check("mul_depth", 32'(depth), 32'd1);

    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1, 1, 16'(i * 3 + 1));
    cycle(1, 9, 0);  check("dup_rej_op", 32'(obs_op), 32'd0);
    check("dup_rej_err", 32'(err), 32'd1);
    check("dup_rej_depth", 32'(depth), 32'(DEPTH));
    cycle(1, 7, 0);  check("pop2_op", 32'(obs_op), 32'd4);
    check("pop2_depth", 32'(depth), 32'(DEPTH - 2));

    cycle(1, 8, 0); cycle(1, 8, 0); cycle(1, 11, 0);
    for (int i = 0; i < 9; i++) cycle(0, 0, 0);
    Reset = 1; stk.delete(); m_err = 0; m_busy = 0;
    #2;
    check("midmul_busy", 32'(busy), 32'd0);
    check("midmul_depth", 32'(depth), 32'd0);
    check("midmul_err", 32'(err), 32'd0);
    check("midmul_op", 32'(stackOP), 32'd0);
    @(posedge CLK); #1;
    cycle(0, 0, 0);
    Reset = 0;
    cycle(1, 1, 16'h00AA);
    check("post_reset_ready", 32'(obs_ready), 32'd1);
    check("post_reset_op", 32'(obs_op), 32'd1);

    do_reset();
    cycle(1, 1, 16'hFFFF); cycle(1, 1, 16'h0001);
    cycle(1, 2, 0);  check("wrap_w", 32'(obs_w), 32'd0);
    check("wrap_op", 32'(obs_op), 32'd2);
    check("wrap_err", 32'(err), 32'd0);

    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i % 997 == 500) do_reset();
      rop = ($urandom_range(0, 2) == 0) ? 4'd1 : 4'($urandom_range(0, 15));
      cycle($urandom_range(0, 9) < 7, rop, 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
